// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: states, opcodes,
// datapath mux/ALU codes and the bundle of Moore control outputs.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       branch;
    logic       pc_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_out_decode.sv
// State-to-control decode for the multicycle controller; purely combinational,
// every field not set for a state stays 0.
module mcc_out_decode
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] i_state,
  output ctrl_t              o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      STATE_W'(S_FETCH): begin
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
      end
      STATE_W'(S_DECODE): begin
        o_ctrl.alu_src_b = SRCB_BRANCH;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      STATE_W'(S_MEMADR), STATE_W'(S_ADDIEX): begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      STATE_W'(S_MEMRD): o_ctrl.iord = 1'b1;
      STATE_W'(S_MEMWR): begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      STATE_W'(S_MEMWB): begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      STATE_W'(S_EXEC): begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      STATE_W'(S_ADDIWB): o_ctrl.reg_write = 1'b1;
      STATE_W'(S_BRANCH): begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
      end
      STATE_W'(S_JUMP): begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: state register and next-state logic here, Moore output
// decode in mcc_out_decode; write/enable strobes are masked while reset is high.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic               branch,
  output logic               pc_write,
  output logic               pc_en,
  output logic               illegal,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  ctrl_t              w_ctrl;

  always_ff @(posedge clock) begin
    if (reset) r_state <= STATE_W'(S_FETCH);
    else       r_state <= w_next;
  end

  // Opcode is only consulted in DECODE and MEMADR; undefined encodings fall to FETCH.
  always_comb begin
    w_next = STATE_W'(S_FETCH);
    case (r_state)
      STATE_W'(S_FETCH): w_next = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): begin
        case (opcode)
          OP_LW, OP_SW: w_next = STATE_W'(S_MEMADR);
          OP_RTYPE:     w_next = STATE_W'(S_EXEC);
          OP_BEQ:       w_next = STATE_W'(S_BRANCH);
          OP_ADDI:      w_next = STATE_W'(S_ADDIEX);
          OP_J:         w_next = STATE_W'(S_JUMP);
          default:      w_next = STATE_W'(S_FETCH);
        endcase
      end
      STATE_W'(S_MEMADR): w_next = (opcode == OP_SW) ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
      STATE_W'(S_MEMRD):  w_next = STATE_W'(S_MEMWB);
      STATE_W'(S_EXEC):   w_next = STATE_W'(S_ALUWB);
      STATE_W'(S_ADDIEX): w_next = STATE_W'(S_ADDIWB);
      default:            w_next = STATE_W'(S_FETCH);
    endcase
  end

  mcc_out_decode #(.STATE_W(STATE_W)) u_out_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // illegal is the one output that looks at opcode: it flags the DECODE cycle itself.
  always_comb begin
    iord       = w_ctrl.iord;
    reg_dst    = w_ctrl.reg_dst;
    mem_to_reg = w_ctrl.mem_to_reg;
    alu_src_a  = w_ctrl.alu_src_a;
    branch     = w_ctrl.branch;
    alu_src_b  = w_ctrl.alu_src_b;
    alu_op     = w_ctrl.alu_op;
    pc_src     = w_ctrl.pc_src;
    ir_write   = w_ctrl.ir_write  & ~reset;
    pc_write   = w_ctrl.pc_write  & ~reset;
    mem_write  = w_ctrl.mem_write & ~reset;
    reg_write  = w_ctrl.reg_write & ~reset;
    pc_en      = (w_ctrl.pc_write | (w_ctrl.branch & zero)) & ~reset;
    illegal    = (r_state == STATE_W'(S_DECODE)) & ~is_known_op(opcode) & ~reset;
    state      = r_state;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table followed by
// hand-written instruction latency sequences.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, branch, pc_write, pc_en, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multicycle_control #(.STATE_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .branch     (branch),
    .pc_write   (pc_write),
    .pc_en      (pc_en),
    .illegal    (illegal),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state)
  );

  // Field order: iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
  // branch pc_write pc_en illegal | alu_src_b alu_op pc_src
  logic [16:0] w_act;
  assign w_act = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  branch, pc_write, pc_en, illegal, alu_src_b, alu_op, pc_src};

  localparam logic [16:0] E_FETCH     = 17'b0_0_1_0_0_0_0_0_1_1_0_01_00_00;
  localparam logic [16:0] E_FETCH_RST = 17'b0_0_0_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] E_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_1_11_00_00;
  localparam logic [16:0] E_MEMADR    = 17'b0_0_0_0_0_0_1_0_0_0_0_10_00_00;
  localparam logic [16:0] E_MEMRD     = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_MEMWR     = 17'b1_1_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_MEMWR_RST = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_MEMWB     = 17'b0_0_0_0_1_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_EXEC      = 17'b0_0_0_0_0_0_1_0_0_0_0_00_10_00;
  localparam logic [16:0] E_ALUWB     = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_ADDIWB    = 17'b0_0_0_0_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_BR_T      = 17'b0_0_0_0_0_0_1_1_0_1_0_00_01_01;
  localparam logic [16:0] E_BR_N      = 17'b0_0_0_0_0_0_1_1_0_0_0_00_01_01;
  localparam logic [16:0] E_JUMP      = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_10;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [16:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic z,
                     input logic [3:0] st, input logic [16:0] exp);
    vq.push_back('{rst, op, z, st, exp});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input int exp_lat,
                           input int exp_ill, input int exp_wr);
    int cyc   = 0;
    int ill_n = 0;
    int wr_n  = 0;
    opcode = op;
    zero   = 1'b0;
    do begin
      @(negedge clock);
      if (illegal) ill_n++;
      if (reg_write | mem_write) wr_n++;
      @(posedge clock);
      #1;
      cyc++;
    end while (state != 4'(S_FETCH) && cyc < 20);
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_illegal_pulses"}, 32'(ill_n), 32'(exp_ill));
    check({name, "_write_cycles"}, 32'(wr_n), 32'(exp_wr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    opcode = OP_RTYPE;
    zero   = 1'b0;

    add(1, OP_LW,    0, S_FETCH,  E_FETCH_RST);
    // lw, with opcode garbage in states that must ignore it
    add(0, OP_LW,    0, S_FETCH,  E_FETCH);
    add(0, OP_LW,    0, S_DECODE, E_DECODE);
    add(0, OP_LW,    0, S_MEMADR, E_MEMADR);
    add(0, 6'h3F,    0, S_MEMRD,  E_MEMRD);
    add(0, OP_BEQ,   0, S_MEMWB,  E_MEMWB);
    // sw
    add(0, OP_SW,    0, S_FETCH,  E_FETCH);
    add(0, OP_SW,    0, S_DECODE, E_DECODE);
    add(0, OP_SW,    0, S_MEMADR, E_MEMADR);
    add(0, OP_LW,    0, S_MEMWR,  E_MEMWR);
    // R-type
    add(0, OP_RTYPE, 0, S_FETCH,  E_FETCH);
    add(0, OP_RTYPE, 0, S_DECODE, E_DECODE);
    add(0, OP_J,     0, S_EXEC,   E_EXEC);
    add(0, OP_RTYPE, 0, S_ALUWB,  E_ALUWB);
    // beq taken, zero high outside BRANCH must not raise pc_en there
    add(0, OP_BEQ,   1, S_FETCH,  E_FETCH);
    add(0, OP_BEQ,   1, S_DECODE, E_DECODE);
    add(0, OP_BEQ,   1, S_BRANCH, E_BR_T);
    // beq not taken
    add(0, OP_BEQ,   0, S_FETCH,  E_FETCH);
    add(0, OP_BEQ,   0, S_DECODE, E_DECODE);
    add(0, OP_BEQ,   0, S_BRANCH, E_BR_N);
    // illegal opcode
    add(0, 6'h3F,    0, S_FETCH,  E_FETCH);
    add(0, 6'h3F,    0, S_DECODE, E_DEC_ILL);
    // jump
    add(0, OP_J,     0, S_FETCH,  E_FETCH);
    add(0, OP_J,     0, S_DECODE, E_DECODE);
    add(0, OP_J,     0, S_JUMP,   E_JUMP);
    // sw aborted by reset in MEMWR, then addi
    add(0, OP_SW,    0, S_FETCH,  E_FETCH);
    add(0, OP_SW,    0, S_DECODE, E_DECODE);
    add(0, OP_SW,    0, S_MEMADR, E_MEMADR);
    add(1, OP_SW,    0, S_MEMWR,  E_MEMWR_RST);
    add(0, OP_ADDI,  0, S_FETCH,  E_FETCH);
    add(0, OP_ADDI,  0, S_DECODE, E_DECODE);
    add(0, OP_ADDI,  0, S_ADDIEX, E_MEMADR);
    add(0, OP_ADDI,  0, S_ADDIWB, E_ADDIWB);
    add(0, OP_ADDI,  0, S_FETCH,  E_FETCH);
    // reset in the middle of lw
    add(0, OP_LW,    0, S_DECODE, E_DECODE);
    add(1, OP_LW,    0, S_MEMADR, E_MEMADR);
    add(0, OP_LW,    0, S_FETCH,  E_FETCH);

    repeat (2) @(posedge clock);

    foreach (vq[i]) begin
      @(posedge clock);
      #1;
      reset  = vq[i].rst;
      opcode = vq[i].op;
      zero   = vq[i].z;
      @(negedge clock);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vq[i].st));
      check($sformatf("vec%0d_outputs", i), 32'(w_act), 32'(vq[i].exp));
    end

    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("post_reset_state", 32'(state), 32'(S_FETCH));

    run_instr("lw",      OP_LW,    5, 0, 1);
    run_instr("sw",      OP_SW,    4, 0, 1);
    run_instr("rtype",   OP_RTYPE, 4, 0, 1);
    run_instr("addi",    OP_ADDI,  4, 0, 1);
    run_instr("beq",     OP_BEQ,   3, 0, 0);
    run_instr("j",       OP_J,     3, 0, 0);
    run_instr("illegal", 6'h3F,    2, 1, 0);
    run_instr("illegal2", 6'b110000, 2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
